// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment scan driver.
// Segment vectors are active-low with bit 6..0 = a,b,c,d,e,f,g.
package seg_pkg;

  localparam int SEG_W = 7;
  localparam int SEG_A = 6;
  localparam int SEG_B = 5;
  localparam int SEG_C = 4;
  localparam int SEG_D = 3;
  localparam int SEG_E = 2;
  localparam int SEG_F = 1;
  localparam int SEG_G = 0;

  localparam logic [SEG_W-1:0] SEG_DASH  = 7'b1111110;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

  // Element 15 is listed first so that HEX_SEG[v] is the glyph for nibble v.
  localparam logic [15:0][SEG_W-1:0] HEX_SEG = {
    7'b0111000,  // F
    7'b0110000,  // E
    7'b1000010,  // d
    7'b0110001,  // C
    7'b1100000,  // b
    7'b0001000,  // A
    7'b0000100,  // 9
    7'b0000000,  // 8
    7'b0001111,  // 7
    7'b0100000,  // 6
    7'b0100100,  // 5
    7'b1001100,  // 4
    7'b0000110,  // 3
    7'b0010010,  // 2
    7'b1001111,  // 1
    7'b0000001   // 0
  };

endpackage

// File: rtl/seg_scan_driver_hex_decode.sv
// Combinational nibble to active-low abcdefg glyph decoder.
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0]       nibble,
  output logic [SEG_W-1:0] seg
);

  assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed N-digit common-anode 7-segment driver with frame-aligned
// commit of new digit data, per-digit blank and blink.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic [NUM_DIGITS-1:0]   blink_in,
  output logic [SEG_W-1:0]        seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int DIV_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_FRAMES - 1);

  logic [DIV_W-1:0]        div_cnt_reg;
  logic [IDX_W-1:0]        idx_reg;
  logic [BLK_W-1:0]        blink_cnt_reg;
  logic                    blink_phase_reg;
  logic                    pending_reg;
  logic                    dash_mode_reg;
  logic [4*NUM_DIGITS-1:0] pend_digits_reg, com_digits_reg;
  logic [NUM_DIGITS-1:0]   pend_blank_reg, com_blank_reg;
  logic [NUM_DIGITS-1:0]   pend_blink_reg, com_blink_reg;

  logic                    slot_end;
  logic                    frame_end;
  logic [3:0]              cur_nibble;
  logic [SEG_W-1:0]        hex_seg;
  logic [SEG_W-1:0]        seg_next;
  logic [NUM_DIGITS-1:0]   an_next;

  assign slot_end   = (div_cnt_reg == DIV_LAST);
  assign frame_end  = slot_end && (idx_reg == IDX_LAST);
  assign cur_nibble = com_digits_reg[4*int'(idx_reg) +: 4];

  seg_hex_decode u_hex_decode (
    .nibble (cur_nibble),
    .seg    (hex_seg)
  );

  always_comb begin
    seg_next = hex_seg;
    if (dash_mode_reg) begin
      seg_next = SEG_DASH;
    end else if (com_blank_reg[idx_reg] || (com_blink_reg[idx_reg] && blink_phase_reg)) begin
      seg_next = SEG_BLANK;
    end
  end

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_an
    assign an_next[gi] = (idx_reg != IDX_W'(gi));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_reg     <= '0;
      idx_reg         <= '0;
      blink_cnt_reg   <= '0;
      blink_phase_reg <= 1'b0;
      pending_reg     <= 1'b0;
      dash_mode_reg   <= 1'b1;
      pend_digits_reg <= '0;
      pend_blank_reg  <= '0;
      pend_blink_reg  <= '0;
      com_digits_reg  <= '0;
      com_blank_reg   <= '0;
      com_blink_reg   <= '0;
      seg             <= SEG_DASH;
      an              <= ~NUM_DIGITS'(1);
      frame_done      <= 1'b0;
    end else begin
      div_cnt_reg <= slot_end ? '0 : div_cnt_reg + DIV_W'(1);
      if (slot_end) begin
        idx_reg <= (idx_reg == IDX_LAST) ? '0 : idx_reg + IDX_W'(1);
      end

      if (load) begin
        pend_digits_reg <= digits_in;
        pend_blank_reg  <= blank_in;
        pend_blink_reg  <= blink_in;
        pending_reg     <= 1'b1;
      end

      // A load landing on the boundary commits directly; pending is cleared
      // either way because the later assignment below takes precedence.
      if (frame_end) begin
        if (blink_cnt_reg == BLK_LAST) begin
          blink_cnt_reg   <= '0;
          blink_phase_reg <= ~blink_phase_reg;
        end else begin
          blink_cnt_reg <= blink_cnt_reg + BLK_W'(1);
        end
        if (load) begin
          com_digits_reg <= digits_in;
          com_blank_reg  <= blank_in;
          com_blink_reg  <= blink_in;
          pending_reg    <= 1'b0;
          dash_mode_reg  <= 1'b0;
        end else if (pending_reg) begin
          com_digits_reg <= pend_digits_reg;
          com_blank_reg  <= pend_blank_reg;
          com_blink_reg  <= pend_blink_reg;
          pending_reg    <= 1'b0;
          dash_mode_reg  <= 1'b0;
        end
      end

      seg        <= seg_next;
      an         <= an_next;
      frame_done <= frame_end;
    end
  end

endmodule
